// File: rtl/ascon_perm_core_if.sv
// ---------------------------------------------------------------------------
// ascon_perm_core_if
//   Start/done handshake and state bus between the permutation register file
//   (master) and the Ascon permutation core (slave).
//
//   start      master -> slave  request pulse, sampled on rising clk
//   rounds     master -> slave  round count a (values > 12 mean 12)
//   state_in   master -> slave  320-bit input state {x0,x1,x2,x3,x4}
//   state_out  slave -> master  permuted state, valid with done, then held
//   busy       slave -> master  rounds executing
//   done       slave -> master  one-cycle completion pulse
// ---------------------------------------------------------------------------
interface ascon_perm_core_if;
    logic         start;
    logic [3:0]   rounds;
    logic [319:0] state_in;
    logic [319:0] state_out;
    logic         busy;
    logic         done;

    modport master (
        output start,
        output rounds,
        output state_in,
        input  state_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  rounds,
        input  state_in,
        output state_out,
        output busy,
        output done
    );
endinterface

// File: rtl/ascon_perm_core.sv
// ---------------------------------------------------------------------------
// ascon_perm_core
//   Iterative Ascon permutation p^a (a = 0..12) over the 320-bit state.
//   UNROLL rounds are evaluated per clock (1 or 2).
//
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     ascon_perm_core_if.slave: start/rounds/state_in in,
//           state_out/busy/done out
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; state_out holds the last result
//   RUN     | applying rounds idx_q (and idx_q+1 when UNROLL=2)
//   DONE    | done pulse; a new start is accepted here without a gap
// ---------------------------------------------------------------------------
module ascon_perm_core #(
    parameter int UNROLL = 1
) (
    input  logic              clk,
    input  logic              resetn,
    ascon_perm_core_if.slave  bus
);

    generate
        if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
            $error("ascon_perm_core: UNROLL must be 1 or 2");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] STEP     = 4'(UNROLL);
    localparam logic [3:0] LAST_IDX = 4'd11;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One full round pC -> pS -> pL with round-constant index i.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];

        x2 = x2 ^ {56'd0, 4'(4'd15 - i), i};

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [319:0] state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [319:0] out_q, out_d;

    logic [319:0] round1, round2, run_next;
    logic         last_step;
    logic         start_ok;
    logic [3:0]   rounds_eff;

    always_comb begin
        round1 = ascon_round(state_q, idx_q);
        round2 = ascon_round(round1, idx_q + 4'd1);
        // With two rounds per clock an odd count ends on a single round 11.
        if (UNROLL == 2) begin
            run_next  = (idx_q == LAST_IDX) ? round1 : round2;
            last_step = (idx_q >= 4'd10);
        end else begin
            run_next  = round1;
            last_step = (idx_q == LAST_IDX);
        end
    end

    assign rounds_eff = (bus.rounds > 4'd12) ? 4'd12 : bus.rounds;
    assign start_ok   = bus.start && (fsm_q != ST_RUN);

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        idx_d   = idx_q;
        out_d   = out_q;

        case (fsm_q)
            ST_RUN: begin
                state_d = run_next;
                idx_d   = idx_q + STEP;
                if (last_step) begin
                    fsm_d = ST_DONE;
                    out_d = run_next;
                end
            end
            ST_DONE: fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase

        // A start in DONE overrides the return to IDLE; out_q is only written
        // when the new operation itself reaches DONE, so the previous result
        // stays visible until then.
        if (start_ok) begin
            state_d = bus.state_in;
            idx_d   = 4'd12 - rounds_eff;
            if (rounds_eff == 4'd0) begin
                fsm_d = ST_DONE;
                out_d = bus.state_in;
            end else begin
                fsm_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            idx_q   <= '0;
            out_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
        end
    end

    assign bus.state_out = out_q;
    assign bus.busy      = (fsm_q == ST_RUN);
    assign bus.done      = (fsm_q == ST_DONE);

endmodule
